seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised sequential ALU that succeeds the combinational 4-op ALU in the execute stage.
//  Accepts one operation per valid/ready handshake and returns a registered result with status flags.
//  Logic/arith/shift/compare ops complete in one cycle; MUL (shift-add) and DIVU/REMU (restoring) iterate.
//  Execute-stage control stalls the pipeline on in_ready/out_valid.
// PARAMETERS
//  WIDTH  32  datapath width; power of two, >= 8
//  OP_W   5   width of sig_alu_control
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  in_valid         in   1      operands/op valid
//  in_ready         out  1      block accepts operation this cycle
//  src_a            in   WIDTH  operand A
//  src_b            in   WIDTH  operand B
//  sig_alu_control  in   OP_W   operation code (shared package)
//  out_valid        out  1      result/flags valid
//  out_ready        in   1      consumer takes result this cycle
//  result           out  WIDTH  result
//  zero             out  1      result == 0
//  overflow         out  1      signed overflow (ADD/SUB only, else 0)
//  div_by_zero      out  1      DIVU/REMU with src_b == 0
//  illegal_op       out  1      unknown opcode
//  busy             out  1      multi-cycle op in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, result, zero, overflow, div_by_zero, illegal_op, busy all 0.
//  Reset mid-operation aborts the op with no output.
//  Accept: in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  A new op is accepted in the same cycle the old result drains.
//  Ops: AND, OR, XOR, ADD, SUB, SLT (signed, result 0/1), SLL, SRL.
//  Shift amount = src_b[$clog2(WIDTH)-1:0].
//  ADD/SUB wrap modulo 2^WIDTH. Overflow = operand signs match (ADD) or differ (SUB) and result sign differs from A.
//  Single-cycle latency: out_valid rises the cycle after accept.
//  MUL: low WIDTH bits of unsigned product; state MUL for WIDTH cycles; out_valid at accept+WIDTH+1.
//  DIVU/REMU: restoring divide; state DIV for WIDTH cycles; same latency as MUL.
//  Divide by zero: short-circuits to DONE in 1 cycle. DIVU result = all ones; REMU result = src_a; div_by_zero=1.
//  Illegal opcode: 1-cycle latency, result=0, illegal_op=1. No simulation print.
//  FSM: IDLE -> (MUL|DIV on accept of iterative op) -> DONE -> IDLE when out_ready.
//  Single-cycle ops load the output register directly from IDLE.
//  Iteration counter is $clog2(WIDTH)+1 bits and counts down to 0; busy = state in {MUL,DIV}.
//  Output hold: result and all flags stay stable while out_valid & ~out_ready.
//  out_valid drops the cycle after a handshake unless a new single-cycle op was accepted.
//  Operands are captured at accept; input changes during iteration are ignored.
// CONFIGURATION
//  SEQ_ALU_DIV_EN defined: DIVU/REMU and the DIV state/divider datapath are built.
//  SEQ_ALU_DIV_EN undefined: DIVU/REMU are treated as illegal opcodes (result 0, illegal_op=1, 1-cycle).
//  With the macro undefined, div_by_zero is tied to 0 and no divider logic is synthesised.
// STRUCTURE
//  Shared package alu_pkg holds the opcodes:
//    AND=0, OR=1, ADD=2, SUB=3, XOR=4, SLT=5, SLL=6, SRL=7, MUL=8, DIVU=9, REMU=10.
//  alu_pkg also holds the FSM state encoding: IDLE, MUL, DIV, DONE.
//  One sub-module, seq_alu_iter: shared shift-add/restoring-divide datapath with start/done.
//  seq_alu owns the handshake, single-cycle ops, and the output register.
// TESTING
//  ADD 0x7FFFFFFF+1, out_ready=1 -> result 0x80000000, overflow=1, out_valid at accept+1.
//  SUB 5-5 -> result 0, zero=1. SLT 0xFFFFFFFF,1 -> result 1.
//  MUL 0x10000*0x10003 -> result 0x00030000, out_valid exactly accept+33, busy high 32 cycles.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU x/0 -> 0xFFFFFFFF, div_by_zero=1.
//  Build without SEQ_ALU_DIV_EN: DIVU -> illegal_op=1, result 0.
//  Hold out_ready=0 for 5 cycles: result stable, in_ready=0. Release -> back-to-back ADDs, 1 op/cycle.
//  Assert rst_n=0 mid-MUL -> all outputs 0 asynchronously. Next op after reset completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for seq_alu and its iterative datapath.
// Divider support is built only when SEQ_ALU_DIV_EN is defined.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_OR   = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLT  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_MUL  = 5'd8,
        OP_DIVU = 5'd9,
        OP_REMU = 5'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    typedef enum logic [1:0] {
        IT_MUL  = 2'd0,
        IT_DIVU = 2'd1,
        IT_REMU = 2'd2
    } iter_mode_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic illegal_op;
    } alu_flags_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add multiply and (with SEQ_ALU_DIV_EN) restoring divide.
// One step per cycle for WIDTH cycles; done_o marks the cycle whose step produces result_o.
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
    input  iter_mode_e       mode_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc: product accumulator / partial remainder
    // x:   shifted multiplicand / dividend shifting into quotient
    // y:   multiplier shifting right / divisor
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

`ifdef SEQ_ALU_DIV_EN
    iter_mode_e       mode_q;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;
`endif

    always_comb begin
        acc_d    = acc_q + (y_q[0] ? x_q : '0);
        x_d      = x_q << 1;
        y_d      = y_q >> 1;
        result_o = acc_d;
`ifdef SEQ_ALU_DIV_EN
        rsh  = {acc_q, x_q[WIDTH-1]};
        diff = rsh - {1'b0, y_q};
        if (mode_q != IT_MUL) begin
            // Borrow out of diff means the shifted remainder was smaller than the divisor.
            y_d      = y_q;
            acc_d    = diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
            x_d      = {x_q[WIDTH-2:0], ~diff[WIDTH]};
            result_o = (mode_q == IT_REMU) ? acc_d : x_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= IT_MUL;
`endif
        end else if (start_i) begin
            cnt_q  <= CNT_W'(WIDTH);
            acc_q  <= '0;
            x_q    <= a_i;
            y_q    <= b_i;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= mode_i;
`endif
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake: single-cycle logic/arith/shift ops, iterative MUL,
// and DIVU/REMU when SEQ_ALU_DIV_EN is defined (otherwise those opcodes report illegal_op).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [OP_W-1:0]  sig_alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;

    logic [4:0]       op;
    logic             accept;
    logic [WIDTH-1:0] sum, dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf, sc_ill;

    logic             iter_start, iter_done;
    logic [WIDTH-1:0] iter_res;

`ifdef SEQ_ALU_DIV_EN
    logic             dbz_q, dbz_d;
    iter_mode_e       iter_mode;
`endif

    assign op       = 5'(sig_alu_control);
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = src_a + src_b;
    assign dif      = src_a - src_b;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_AND: sc_res = src_a & src_b;
            OP_OR:  sc_res = src_a | src_b;
            OP_XOR: sc_res = src_a ^ src_b;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SLT: sc_res = WIDTH'($signed(src_a) < $signed(src_b));
            OP_SLL: sc_res = src_a << src_b[SH_W-1:0];
            OP_SRL: sc_res = src_a >> src_b[SH_W-1:0];
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        res_d       = res_q;
        flags_d     = flags_q;
        iter_start  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        dbz_d       = dbz_q;
        iter_mode   = IT_MUL;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        iter_start = 1'b1;
                        state_d    = MUL;
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (op == OP_DIVU || op == OP_REMU) begin
                        iter_mode = (op == OP_REMU) ? IT_REMU : IT_DIVU;
                        if (src_b == '0) begin
                            res_d            = (op == OP_REMU) ? src_a : '1;
                            flags_d.overflow = 1'b0;
                            flags_d.illegal_op = 1'b0;
                            dbz_d            = 1'b1;
                            out_valid_d      = 1'b1;
                            state_d          = DONE;
                        end else begin
                            iter_start = 1'b1;
                            state_d    = DIV;
                        end
                    end
`endif
                    else begin
                        res_d              = sc_res;
                        flags_d.overflow   = sc_ovf;
                        flags_d.illegal_op = sc_ill;
`ifdef SEQ_ALU_DIV_EN
                        dbz_d              = 1'b0;
`endif
                        out_valid_d        = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                if (iter_done) begin
                    res_d              = iter_res;
                    flags_d.overflow   = 1'b0;
                    flags_d.illegal_op = 1'b0;
`ifdef SEQ_ALU_DIV_EN
                    dbz_d              = 1'b0;
`endif
                    out_valid_d        = 1'b1;
                    state_d            = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // While holding, res_d == res_q so zero stays stable as well.
        flags_d.zero = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

`ifdef SEQ_ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbz_q <= 1'b0;
        else        dbz_q <= dbz_d;
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .mode_i   (iter_mode),
`endif
        .a_i      (src_a),
        .b_i      (src_b),
        .done_o   (iter_done),
        .result_o (iter_res)
    );

    assign out_valid  = out_valid_q;
    assign result     = res_q;
    assign zero       = flags_q.zero;
    assign overflow   = flags_q.overflow;
    assign illegal_op = flags_q.illegal_op;
    assign busy       = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table through a scoreboard plus timing/hold/reset sequences.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [4:0]   ctl = '0;
    logic         in_ready, out_valid, zero, overflow, div_by_zero, illegal_op, busy;
    logic [W-1:0] result;

    seq_alu #(.WIDTH(W), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b), .sig_alu_control(ctl),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero),
        .illegal_op(illegal_op), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b, res;
        logic         z, ov, dz, il;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];
    vec_t chk_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [4:0] op, input logic [W-1:0] a, b, res,
                                input logic ov, dz, il);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.z = (res == '0); v.ov = ov; v.dz = dz; v.il = il;
        return v;
    endfunction

    function automatic vec_t mkdiv(input logic [4:0] op, input logic [W-1:0] a, b, res,
                                   input logic dz);
`ifdef SEQ_ALU_DIV_EN
        return mk(op, a, b, res, 1'b0, dz, 1'b0);
`else
        return mk(op, a, b, '0, 1'b0, 1'b0, 1'b1);
`endif
    endfunction

    // Scoreboard: compare every result taken by the consumer against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got res=%h, required no output", result);
            end else begin
                chk_e = exp_q.pop_front();
                if (result !== chk_e.res || zero !== chk_e.z || overflow !== chk_e.ov ||
                    div_by_zero !== chk_e.dz || illegal_op !== chk_e.il) begin
                    n_bad++;
                    $display("FAIL op%0d a=%h b=%h: got res=%h z=%b ov=%b dz=%b il=%b, required res=%h z=%b ov=%b dz=%b il=%b",
                             chk_e.op, chk_e.a, chk_e.b, result, zero, overflow, div_by_zero,
                             illegal_op, chk_e.res, chk_e.z, chk_e.ov, chk_e.dz, chk_e.il);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic issue(input vec_t v);
        int k;
        in_valid = 1'b1;
        ctl = v.op; src_a = v.a; src_b = v.b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 200);
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout op%0d: in_ready=0 after %0d cycles, required 1", v.op, k);
        end else begin
            exp_q.push_back(v);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom(); src_b = $urandom(); ctl = 5'($urandom_range(0, 10));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, bc, c0;

        vecs.push_back(mk(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0));
        vecs.push_back(mk(OP_SUB, 32'd5, 32'd5, 32'h0, 0, 0, 0));
        vecs.push_back(mk(OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0));
        vecs.push_back(mk(OP_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0));
        vecs.push_back(mk(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0));
        vecs.push_back(mk(OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0));
        vecs.push_back(mk(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 0, 0, 0));
        vecs.push_back(mk(OP_SLL, 32'h1, 32'd35, 32'h8, 0, 0, 0));
        vecs.push_back(mk(OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 0, 0, 0));
        vecs.push_back(mk(OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 0, 0));
        vecs.push_back(mk(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(5'd15, 32'd5, 32'd6, 32'h0, 0, 0, 1));
        vecs.push_back(mk(5'd31, 32'd5, 32'd6, 32'h0, 0, 0, 1));
        vecs.push_back(mk(OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 0, 0, 0));
        vecs.push_back(mk(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 0, 0));
        vecs.push_back(mk(OP_ADD, 32'd40, 32'd2, 32'd42, 0, 0, 0));
        vecs.push_back(mkdiv(OP_DIVU, 32'd100, 32'd7, 32'd14, 0));
        vecs.push_back(mkdiv(OP_REMU, 32'd100, 32'd7, 32'd2, 0));
        vecs.push_back(mkdiv(OP_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1));
        vecs.push_back(mkdiv(OP_REMU, 32'h0000_1234, 32'h0, 32'h0000_1234, 1));
        vecs.push_back(mkdiv(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0));
        vecs.push_back(mkdiv(OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 0));
        vecs.push_back(mkdiv(OP_DIVU, 32'd3, 32'd7, 32'h0, 0));

        #1;
        chk("reset_out_valid", W'(out_valid), '0);
        chk("reset_result", result, '0);
        chk("reset_flags_busy", W'({zero, overflow, div_by_zero, illegal_op, busy}), '0);
        chk("reset_in_ready", W'(in_ready), W'(1));
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        foreach (vecs[i]) issue(vecs[i]);
        drain();

        // Single-cycle latency
        issue(mk(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0));
        chk("add_latency_out_valid", W'(out_valid), W'(1));
        drain();

        // MUL latency and busy window
        issue(mk(OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 0, 0, 0));
        lat = 0; bc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end while (!out_valid && lat < 100);
        chk("mul_latency", W'(lat), W'(33));
        chk("mul_busy_cycles", W'(bc), W'(32));
        @(posedge clk); #1;

        // Output hold with stalled consumer, then back-to-back accepts
        out_ready = 1'b0;
        issue(mk(OP_ADD, 32'd10, 32'd20, 32'd30, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", W'(out_valid), W'(1));
            chk("hold_result", result, 32'd30);
            chk("hold_in_ready", W'(in_ready), '0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4; k++)
            issue(mk(OP_ADD, W'(k), W'(3 * k), W'(4 * k), 0, 0, 0));
        chk("back_to_back_cycles", W'(cyc - c0), W'(4));
        drain();

        // Asynchronous reset in the middle of a MUL
        issue(mk(OP_MUL, 32'd3, 32'd5, 32'd15, 0, 0, 0));
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", W'(out_valid), '0);
        chk("midreset_busy", W'(busy), '0);
        chk("midreset_result", result, '0);
        chk("midreset_flags", W'({zero, overflow, div_by_zero, illegal_op}), '0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(mk(OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0));
        issue(mk(OP_MUL, 32'd7, 32'd6, 32'd42, 0, 0, 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
